// File: rtl/umi_pkg.sv
// Shared UMI definitions: opcodes, packet field offsets and endpoint FSM state encoding.
package umi_pkg;

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_WRITE   = 8'h02;
  localparam logic [7:0] OP_POSTED  = 8'h03;
  localparam logic [7:0] OP_RESP_RD = 8'h81;
  localparam logic [7:0] OP_RESP_WR = 8'h82;
  localparam logic [7:0] OP_ERR     = 8'hFF;

  localparam int OPC_LSB  = 0;
  localparam int SIZE_LSB = 8;
  localparam int DST_LSB  = 32;
  localparam int SRC_LSB  = 96;
  localparam int DATA_LSB = 160;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE) || (op == OP_POSTED);
  endfunction

endpackage

// File: rtl/umi_endpoint.sv
// UMI responder: one request -> one local register access -> one response packet.
// Define UMI_ENDPOINT_ERR_EN to answer unknown opcodes and timeouts with ERR packets.
module umi_endpoint
  import umi_pkg::*;
#(
  parameter int UW      = 256,
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [UW-1:0] udev_req_packet,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [UW-1:0] udev_resp_packet,
  input  logic          udev_resp_ready,
  output logic [AW-1:0] loc_addr,
  output logic          loc_read,
  output logic          loc_write,
  output logic [DW-1:0] loc_wrdata,
  input  logic [DW-1:0] loc_rddata,
  input  logic          loc_ready
);

`ifdef UMI_ENDPOINT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [7:0]    req_op, req_size, to_cnt, in_op;
  logic [63:0]   req_dst, req_src;
  logic          accept, known, acc_done, timed_out, resp_hs, load_resp;
  logic [7:0]    resp_op, resp_size;
  logic [63:0]   resp_dst, resp_src;
  logic [DW-1:0] resp_data;
  logic          unused_pkt;

  function automatic logic [UW-1:0] format_resp(input logic [7:0] op, input logic [7:0] size,
                                                input logic [63:0] dst, input logic [63:0] src,
                                                input logic [DW-1:0] data);
    logic [UW-1:0] pkt;
    pkt = '0;
    pkt[OPC_LSB +: 8]   = op;
    pkt[SIZE_LSB +: 8]  = size;
    pkt[DST_LSB +: 64]  = dst;
    pkt[SRC_LSB +: 64]  = src;
    pkt[DATA_LSB +: DW] = data;
    return pkt;
  endfunction

  assign in_op      = udev_req_packet[OPC_LSB +: 8];
  assign known      = op_known(in_op);
  assign accept     = udev_req_valid & udev_req_ready;
  assign timed_out  = (state == ST_ACCESS) && !loc_ready && (to_cnt == TO_LAST);
  assign acc_done   = (state == ST_ACCESS) && (loc_ready || (to_cnt == TO_LAST));
  assign resp_hs    = (state == ST_RESP) && udev_resp_ready;
  assign unused_pkt = ^udev_req_packet;

  // Response addresses are swapped relative to the request
  always_comb begin
    state_nxt = state;
    load_resp = 1'b0;
    resp_op   = OP_ERR;
    resp_size = req_size;
    resp_dst  = req_src;
    resp_src  = req_dst;
    resp_data = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (known) begin
            state_nxt = ST_ACCESS;
          end else if (ERR_EN) begin
            state_nxt = ST_RESP;
            load_resp = 1'b1;
            resp_size = udev_req_packet[SIZE_LSB +: 8];
            resp_dst  = udev_req_packet[SRC_LSB +: 64];
            resp_src  = udev_req_packet[DST_LSB +: 64];
          end
        end
      end
      ST_ACCESS: begin
        if (acc_done) begin
          if (req_op == OP_POSTED) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RESP;
            load_resp = 1'b1;
            if (timed_out && ERR_EN) begin
              resp_op = OP_ERR;
            end else if (req_op == OP_READ) begin
              resp_op   = OP_RESP_RD;
              resp_data = timed_out ? '0 : loc_rddata;
            end else begin
              resp_op = OP_RESP_WR;
            end
          end
        end
      end
      ST_RESP: begin
        if (udev_resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Ready re-arms directly on the response handshake; otherwise one cycle after reaching IDLE
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      udev_req_ready   <= 1'b0;
      udev_resp_valid  <= 1'b0;
      udev_resp_packet <= '0;
      loc_addr         <= '0;
      loc_read         <= 1'b0;
      loc_write        <= 1'b0;
      loc_wrdata       <= '0;
      req_op           <= '0;
      req_size         <= '0;
      req_dst          <= '0;
      req_src          <= '0;
      to_cnt           <= '0;
    end else begin
      udev_req_ready  <= ((state == ST_IDLE) && !accept) || resp_hs;
      udev_resp_valid <= (state_nxt == ST_RESP);
      if (load_resp)
        udev_resp_packet <= format_resp(resp_op, resp_size, resp_dst, resp_src, resp_data);
      if (accept) begin
        req_op   <= in_op;
        req_size <= udev_req_packet[SIZE_LSB +: 8];
        req_dst  <= udev_req_packet[DST_LSB +: 64];
        req_src  <= udev_req_packet[SRC_LSB +: 64];
        to_cnt   <= '0;
        if (known) begin
          loc_addr   <= udev_req_packet[DST_LSB +: AW];
          loc_read   <= (in_op == OP_READ);
          loc_write  <= (in_op != OP_READ);
          loc_wrdata <= (in_op == OP_READ) ? '0 : udev_req_packet[DATA_LSB +: DW];
        end
      end else if (state == ST_ACCESS) begin
        if (acc_done) begin
          loc_read  <= 1'b0;
          loc_write <= 1'b0;
        end else begin
          to_cnt <= to_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_umi_endpoint.sv
// Directed bench for umi_endpoint with a packet-level response model and per-cycle output checks.
module tb_umi_endpoint;

  localparam int UW = 256;
  localparam int AW = 64;
  localparam int DW = 64;

`ifdef UMI_ENDPOINT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          udev_req_valid = 1'b0;
  logic [UW-1:0] udev_req_packet = '0;
  logic          udev_req_ready;
  logic          udev_resp_valid;
  logic [UW-1:0] udev_resp_packet;
  logic          udev_resp_ready = 1'b1;
  logic [AW-1:0] loc_addr;
  logic          loc_read;
  logic          loc_write;
  logic [DW-1:0] loc_wrdata;
  logic [DW-1:0] loc_rddata = '0;
  logic          loc_ready = 1'b0;

  always #5 clk = ~clk;

  umi_endpoint #(.UW(UW), .AW(AW), .DW(DW), .TIMEOUT(255)) dut (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(udev_req_valid), .udev_req_packet(udev_req_packet), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_packet(udev_resp_packet), .udev_resp_ready(udev_resp_ready),
    .loc_addr(loc_addr), .loc_read(loc_read), .loc_write(loc_write), .loc_wrdata(loc_wrdata),
    .loc_rddata(loc_rddata), .loc_ready(loc_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Stimulus/model state shared with the responder and monitor
  int           lat = 1;
  logic [63:0]  rd_val = '0;
  logic [63:0]  exp_addr = '0;
  logic [63:0]  exp_wdata = '0;
  bit           exp_is_read = 1'b0;
  logic [255:0] exp_q[$];

  int cyc = 0, acc_cyc = 0, resp_rise_cyc = 0, ready_rise_cyc = 0, hs_cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, v_cnt = 0, resp_count = 0;
  logic [255:0] last_resp = '0;
  logic [255:0] prev_pkt = '0;
  bit prev_pending = 1'b0, prev_v = 1'b0, prev_r = 1'b0;

  function automatic bit model_has_resp(input logic [7:0] op);
    if (op == 8'h03) return 1'b0;
    if (op == 8'h01 || op == 8'h02) return 1'b1;
    return ERR_EN;
  endfunction

  function automatic logic [255:0] model_resp(input logic [7:0] op, input logic [7:0] size,
                                              input logic [63:0] dst, input logic [63:0] src,
                                              input logic [63:0] rdata, input bit to);
    logic [7:0]  rop;
    logic [63:0] d;
    d = 64'h0;
    if (op == 8'h01) begin
      rop = (to && ERR_EN) ? 8'hFF : 8'h81;
      if (!to) d = rdata;
    end else if (op == 8'h02) begin
      rop = (to && ERR_EN) ? 8'hFF : 8'h82;
    end else begin
      rop = 8'hFF;
    end
    return {32'h0, d, dst, src, 16'h0, size, rop};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral: asserts loc_ready on the lat-th strobe cycle (lat==0: never)
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(posedge clk); #1;
      if (nreset && (loc_read || loc_write)) seen++;
      else seen = 0;
      loc_ready  = (lat != 0) && (seen == lat);
      loc_rddata = loc_ready ? rd_val : 64'h0;
    end
  end

  // Per-cycle compare process
  initial forever begin
    @(negedge clk);
    if (!nreset) begin
      prev_pending = 1'b0;
      prev_v = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (udev_req_valid && udev_req_ready) acc_cyc = cyc;
      if (udev_req_ready && !prev_r) ready_rise_cyc = cyc;
      if (udev_resp_valid && !prev_v) resp_rise_cyc = cyc;
      if (udev_resp_valid) v_cnt++;
      if (loc_read) rd_cnt++;
      if (loc_write) wr_cnt++;
      if (loc_read || loc_write) begin
        check("loc_addr", loc_addr, exp_addr);
        check("loc_kind", {loc_read, loc_write}, exp_is_read ? 2'b10 : 2'b01);
        if (loc_write) check("loc_wrdata", loc_wrdata, exp_wdata);
      end
      if (udev_req_ready) check("one_outstanding", {udev_resp_valid, loc_read, loc_write}, 3'b000);
      if (prev_pending) begin
        check("resp_valid_held", udev_resp_valid, 1'b1);
        check("resp_stable", udev_resp_packet, prev_pkt);
      end
      if (udev_resp_valid && udev_resp_ready) begin
        hs_cyc = cyc;
        resp_count++;
        last_resp = udev_resp_packet;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp act=%0h exp=none", udev_resp_packet);
        end else begin
          check("resp_packet", udev_resp_packet, exp_q.pop_front());
        end
      end
      prev_pending = udev_resp_valid && !udev_resp_ready;
      prev_pkt     = udev_resp_packet;
      prev_v       = udev_resp_valid;
      prev_r       = udev_req_ready;
    end
  end

  task automatic send(input logic [7:0] op, input logic [7:0] size, input logic [63:0] dst,
                      input logic [63:0] src, input logic [63:0] data, input int l,
                      input logic [63:0] rdv);
    bit ok;
    ok = 1'b0;
    lat = l;
    rd_val = rdv;
    exp_addr = dst;
    exp_wdata = data;
    exp_is_read = (op == 8'h01);
    @(posedge clk); #1;
    udev_req_packet = {32'h0, data, src, dst, 16'h0, size, op};
    udev_req_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = udev_req_ready;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL req_accept act=no_ready exp=ready");
    end else if (model_has_resp(op)) begin
      exp_q.push_back(model_resp(op, size, dst, src, rdv, l == 0));
    end
    @(posedge clk); #1;
    udev_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0) && udev_req_ready;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_done act=pending(%0d) exp=idle", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_req_ready"}, udev_req_ready, 1'b0);
    check({name, "_resp_valid"}, udev_resp_valid, 1'b0);
    check({name, "_resp_packet"}, udev_resp_packet, 256'h0);
    check({name, "_strobes"}, {loc_read, loc_write}, 2'b00);
    check({name, "_loc_addr"}, loc_addr, 64'h0);
    check({name, "_loc_wrdata"}, loc_wrdata, 64'h0);
  endtask

  initial begin
    int rc;
    bit ok;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 nreset = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", udev_req_ready, 1'b1);

    // READ, loc_ready on third strobe cycle
    rd_cnt = 0; wr_cnt = 0;
    send(8'h01, 8'h03, 64'h1000, 64'h2000, 64'h0, 3, 64'hDEADBEEF);
    wait_done("read3", 50);
    check("read3_strobe_cycles", rd_cnt, 3);
    check("read3_no_write", wr_cnt, 0);
    check("read3_latency", resp_rise_cyc - acc_cyc, 4);
    check("read3_opcode", last_resp[7:0], 8'h81);
    check("read3_size", last_resp[15:8], 8'h03);
    check("read3_dst", last_resp[95:32], 64'h2000);
    check("read3_src", last_resp[159:96], 64'h1000);
    check("read3_data", last_resp[223:160], 64'hDEADBEEF);

    // READ with immediate loc_ready: resp_valid at N+2
    rd_cnt = 0;
    send(8'h01, 8'h07, 64'h88, 64'h99, 64'h0, 1, 64'h0123456789ABCDEF);
    wait_done("read1", 50);
    check("read1_strobe_cycles", rd_cnt, 1);
    check("read1_latency", resp_rise_cyc - acc_cyc, 2);

    // WRITE with response back-pressure for 5 cycles
    udev_resp_ready = 1'b0;
    v_cnt = 0; wr_cnt = 0;
    send(8'h02, 8'h01, 64'h30, 64'h40, 64'h55, 2, 64'h0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (udev_resp_valid) ok = 1'b1;
      else @(negedge clk);
    end
    check("write_resp_seen", ok, 1'b1);
    check("write_stall_ready", udev_req_ready, 1'b0);
    repeat (4) begin
      @(negedge clk);
      check("write_stall_ready", udev_req_ready, 1'b0);
    end
    @(posedge clk); #1 udev_resp_ready = 1'b1;
    @(negedge clk);
    check("write_hs_ready", udev_req_ready, 1'b0);
    wait_done("write", 50);
    check("write_valid_cycles", v_cnt, 6);
    check("write_ready_after_hs", ready_rise_cyc - hs_cyc, 1);
    check("write_strobe_cycles", wr_cnt, 2);
    check("write_opcode", last_resp[7:0], 8'h82);
    check("write_data", last_resp[223:160], 64'h0);

    // POSTED: one write strobe, no response, ready at N+3
    wr_cnt = 0;
    rc = resp_count;
    send(8'h03, 8'h00, 64'h50, 64'h60, 64'hA5A5, 1, 64'h0);
    wait_done("posted", 50);
    check("posted_strobe_cycles", wr_cnt, 1);
    check("posted_no_resp", resp_count - rc, 0);
    check("posted_ready_latency", ready_rise_cyc - acc_cyc, 3);

    // READ timeout: loc_ready never comes
    rd_cnt = 0;
    send(8'h01, 8'h02, 64'h70, 64'h80, 64'h0, 0, 64'hFFFF);
    wait_done("timeout", 400);
    check("timeout_strobe_cycles", rd_cnt, 255);
    check("timeout_latency", resp_rise_cyc - acc_cyc, 256);
    check("timeout_opcode", last_resp[7:0], ERR_EN ? 8'hFF : 8'h81);
    check("timeout_data", last_resp[223:160], 64'h0);

    // Unknown opcode
    rd_cnt = 0; wr_cnt = 0;
    rc = resp_count;
    send(8'h7E, 8'h02, 64'h90, 64'hA0, 64'h11, 1, 64'h0);
    wait_done("unknown", 50);
    check("unknown_no_strobe", rd_cnt + wr_cnt, 0);
`ifdef UMI_ENDPOINT_ERR_EN
    check("unknown_resp_count", resp_count - rc, 1);
    check("unknown_opcode", last_resp[7:0], 8'hFF);
    check("unknown_latency", resp_rise_cyc - acc_cyc, 1);
`else
    check("unknown_resp_count", resp_count - rc, 0);
    check("unknown_ready_latency", ready_rise_cyc - acc_cyc, 2);
`endif

    // Reset during ACCESS drops the transaction
    rc = resp_count;
    send(8'h01, 8'h01, 64'hB0, 64'hC0, 64'h0, 0, 64'h0);
    repeat (3) @(posedge clk);
    #3 nreset = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 nreset = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_no_resp", resp_count - rc, 0);

    // Normal READ after reset release
    rd_cnt = 0;
    send(8'h01, 8'h04, 64'hD0, 64'hE0, 64'h0, 2, 64'hCAFEF00D);
    wait_done("postreset", 50);
    check("postreset_strobe_cycles", rd_cnt, 2);
    check("postreset_opcode", last_resp[7:0], 8'h81);
    check("postreset_data", last_resp[223:160], 64'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
